// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path and the key controller:
// channel state encoding, default 50 MHz timing and key index assignments.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    REL_DEB   = 3'd4
  } keyState_e;

  localparam int DEF_NUM_KEYS     = 5;
  localparam int DEF_DEBOUNCE_CYC = 500_000;     // 10 ms at 50 MHz
  localparam int DEF_LONG_CYC     = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CYC   = 10_000_000;  // 200 ms
  localparam int DEF_CNT_W        = 26;

  localparam int KEY_MODE  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;

  // Smallest counter width able to hold the largest of the three timing constants.
  function automatic int minCntWidth(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: two-flop synchroniser, debounce / long-press / auto-repeat FSM
// and its shared timing counter. Repeat pulses are only issued when the top grants them.
module key_chan
  import key_pkg::*;
#(
  parameter logic KEY_ACTIVE   = 1'b0,
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   LONG_CYC     = DEF_LONG_CYC,
  parameter int   REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int   CNT_W        = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic keyRaw_i,
  input  logic repeatGrant_i,
  output logic repeatReq_o,
  output logic pulse_o,
  output logic level_o,
  output logic long_o
);

  if (CNT_W < minCntWidth(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) begin : gCntWidthErr
    $error("key_chan: CNT_W=%0d too small for configured timing", CNT_W);
  end
  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 2) begin : gTimingErr
    $error("key_chan: timing constants out of range");
  end

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic             sync1_q, sync2_q;
  keyState_e        state_q, stateD;
  logic [CNT_W-1:0] cnt_q, cntD;
  logic             level_q, levelD;
  logic             long_q, longD;
  logic             pulse_q, pulseD;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= (keyRaw_i == KEY_ACTIVE);
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      long_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= stateD;
      cnt_q   <= cntD;
      level_q <= levelD;
      long_q  <= longD;
      pulse_q <= pulseD;
    end
  end

  always_comb begin
    stateD      = state_q;
    cntD        = cnt_q;
    levelD      = level_q;
    longD       = long_q;
    pulseD      = 1'b0;
    repeatReq_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cntD   = '0;
        levelD = 1'b0;
        longD  = 1'b0;
        if (sync2_q) stateD = PRESS_DEB;
      end
      PRESS_DEB: begin
        if (!sync2_q) begin
          stateD = IDLE;
          cntD   = '0;
        end else if (cnt_q == DEB_LAST) begin
          stateD = HELD;
          levelD = 1'b1;
          pulseD = 1'b1;
          cntD   = '0;
        end else begin
          cntD = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          stateD = REL_DEB;
          cntD   = '0;
        end else if (cnt_q == LONG_LAST) begin
          stateD = REPEAT;
          longD  = 1'b1;
          pulseD = 1'b1;
          cntD   = '0;
        end else begin
          cntD = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!sync2_q) begin
          stateD = REL_DEB;
          longD  = 1'b0;
          cntD   = '0;
        end else if (cnt_q == REP_LAST) begin
          // The period keeps running even when the pulse itself is masked.
          repeatReq_o = 1'b1;
          pulseD      = repeatGrant_i;
          cntD        = '0;
        end else begin
          cntD = cnt_q + CNT_W'(1);
        end
      end
      REL_DEB: begin
        longD = 1'b0;
        if (sync2_q) begin
          // Bounce during release: back to HELD silently, long-press timing restarts.
          stateD = HELD;
          cntD   = '0;
        end else if (cnt_q == DEB_LAST) begin
          stateD = IDLE;
          levelD = 1'b0;
          cntD   = '0;
        end else begin
          cntD = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = '0;
        levelD = 1'b0;
        longD  = 1'b0;
      end
    endcase
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;
  assign long_o  = long_q;

endmodule

// File: rtl/key_input_cond.sv
// Conditions the raw push-button bus for the key controller: one key_chan per key,
// auto-repeat masked while several keys are down, plus an any-key summary.
module key_input_cond
  import key_pkg::*;
#(
  parameter int   NUM_KEYS     = DEF_NUM_KEYS,
  parameter logic KEY_ACTIVE   = 1'b0,
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   LONG_CYC     = DEF_LONG_CYC,
  parameter int   REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int   CNT_W        = DEF_CNT_W
) (
  input  logic                CLK,
  input  logic                RESETN,  // synchronous, active-high despite the name
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] KEY_PULSE,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_LONG,
  output logic                ANY_KEY
);

  logic [NUM_KEYS-1:0] repeatReq;
  logic [NUM_KEYS-1:0] repeatGrant;
  logic                multiKey;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multiKey    = (KEY_LEVEL & (KEY_LEVEL - NUM_KEYS'(1))) != '0;
  assign repeatGrant = repeatReq & ~{NUM_KEYS{multiKey}};
  assign ANY_KEY     = |KEY_LEVEL;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gChan
    key_chan #(
      .KEY_ACTIVE  (KEY_ACTIVE),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .CNT_W       (CNT_W)
    ) uChan (
      .clk_i        (CLK),
      .rst_i        (RESETN),
      .keyRaw_i     (KEY[k]),
      .repeatGrant_i(repeatGrant[k]),
      .repeatReq_o  (repeatReq[k]),
      .pulse_o      (KEY_PULSE[k]),
      .level_o      (KEY_LEVEL[k]),
      .long_o       (KEY_LONG[k])
    );
  end

endmodule

// File: tb/tb_key_input_cond.sv
// Self-checking bench for key_input_cond with short timing (debounce 4, long 20, repeat 8).
// Expected pulses are queued as {key, cycle} when keys are driven and matched as they appear.
module tb_key_input_cond;

  localparam int NK  = 5;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
  localparam int LAT = 2 + DEB + 1;

  typedef struct {
    int key;
    int cycle;
  } pulseExp_t;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [NK-1:0] KEY;
  logic [NK-1:0] KEY_PULSE, KEY_LEVEL, KEY_LONG;
  logic          ANY_KEY;

  int        cyc = 0;
  int        total = 0;
  int        bad = 0;
  pulseExp_t expQ[$];

  key_input_cond #(
    .NUM_KEYS    (NK),
    .KEY_ACTIVE  (1'b0),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .REPEAT_CYC  (REP),
    .CNT_W       (8)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .KEY      (KEY),
    .KEY_PULSE(KEY_PULSE),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_LONG (KEY_LONG),
    .ANY_KEY  (ANY_KEY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every observed pulse bit must match the oldest queued expectation.
  always @(negedge CLK) begin
    for (int i = 0; i < NK; i++) begin
      if (KEY_PULSE[i] === 1'b1) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_pulse: got key %0d at cycle %0d, expected no pulse", i, cyc);
        end else begin
          pulseExp_t e;
          e = expQ.pop_front();
          if (e.key !== i || e.cycle !== cyc) begin
            bad++;
            $display("[TB] FAIL pulse_match: got key %0d cycle %0d, expected key %0d cycle %0d",
                     i, cyc, e.key, e.cycle);
          end
        end
      end
    end
  end

  task automatic goCycle(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic test_drained(input string tag);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drained: %0d pulses still pending, expected 0 (next key %0d cycle %0d)",
               tag, expQ.size(), expQ[0].key, expQ[0].cycle);
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b1;
    KEY    = '1;
    repeat (3) @(negedge CLK);
    total += 4;
    if (KEY_PULSE !== '0) begin bad++; $display("[TB] FAIL reset_pulse: got %b expected 0", KEY_PULSE); end
    if (KEY_LEVEL !== '0) begin bad++; $display("[TB] FAIL reset_level: got %b expected 0", KEY_LEVEL); end
    if (KEY_LONG  !== '0) begin bad++; $display("[TB] FAIL reset_long: got %b expected 0", KEY_LONG); end
    if (ANY_KEY   !== 1'b0) begin bad++; $display("[TB] FAIL reset_any: got %b expected 0", ANY_KEY); end
    RESETN = 1'b0;
    repeat (5) @(negedge CLK);
    total++;
    if (KEY_LEVEL !== '0) begin bad++; $display("[TB] FAIL idle_level: got %b expected 0", KEY_LEVEL); end
  endtask

  task automatic test_clean_press();
    int p;
    p = cyc;
    KEY[1] = 1'b0;
    expQ.push_back('{key: 1, cycle: p + LAT});
    goCycle(p + LAT - 1);
    total++;
    if (KEY_LEVEL[1] !== 1'b0) begin bad++; $display("[TB] FAIL press_level_early: got %b expected 0", KEY_LEVEL[1]); end
    goCycle(p + LAT);
    total += 2;
    if (KEY_LEVEL[1] !== 1'b1) begin bad++; $display("[TB] FAIL press_level: got %b expected 1", KEY_LEVEL[1]); end
    if (ANY_KEY !== 1'b1) begin bad++; $display("[TB] FAIL press_any: got %b expected 1", ANY_KEY); end
    goCycle(p + 10);
    KEY[1] = 1'b1;
    goCycle(p + 16);
    total++;
    if (KEY_LEVEL[1] !== 1'b1) begin bad++; $display("[TB] FAIL release_level_hold: got %b expected 1", KEY_LEVEL[1]); end
    goCycle(p + 17);
    total += 2;
    if (KEY_LEVEL[1] !== 1'b0) begin bad++; $display("[TB] FAIL release_level: got %b expected 0", KEY_LEVEL[1]); end
    if (ANY_KEY !== 1'b0) begin bad++; $display("[TB] FAIL release_any: got %b expected 0", ANY_KEY); end
    goCycle(p + 25);
    test_drained("clean_press");
  endtask

  task automatic test_bounce();
    int p;
    p = cyc;
    for (int i = 0; i < 12; i++) begin
      KEY[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge CLK);
      total++;
      if (KEY_LEVEL[0] !== 1'b0) begin bad++; $display("[TB] FAIL bounce_level: got %b expected 0 at cycle %0d", KEY_LEVEL[0], cyc); end
    end
    KEY[0] = 1'b1;
    goCycle(p + 24);
    total++;
    if (KEY_LEVEL[0] !== 1'b0) begin bad++; $display("[TB] FAIL bounce_level_end: got %b expected 0", KEY_LEVEL[0]); end
    test_drained("bounce");
  endtask

  task automatic test_long_hold();
    int p, r;
    p = cyc;
    KEY[2] = 1'b0;
    expQ.push_back('{key: 2, cycle: p + LAT});
    expQ.push_back('{key: 2, cycle: p + LAT + LNG});
    for (int k = 1; k <= 4; k++) expQ.push_back('{key: 2, cycle: p + LAT + LNG + k * REP});
    goCycle(p + LAT + LNG - 1);
    total++;
    if (KEY_LONG[2] !== 1'b0) begin bad++; $display("[TB] FAIL long_early: got %b expected 0", KEY_LONG[2]); end
    goCycle(p + LAT + LNG);
    total++;
    if (KEY_LONG[2] !== 1'b1) begin bad++; $display("[TB] FAIL long_set: got %b expected 1", KEY_LONG[2]); end
    goCycle(p + 60);
    r = cyc;
    KEY[2] = 1'b1;
    goCycle(r + 2);
    total++;
    if (KEY_LONG[2] !== 1'b1) begin bad++; $display("[TB] FAIL long_before_sync: got %b expected 1", KEY_LONG[2]); end
    goCycle(r + 3);
    total += 2;
    if (KEY_LONG[2] !== 1'b0) begin bad++; $display("[TB] FAIL long_drop: got %b expected 0", KEY_LONG[2]); end
    if (KEY_LEVEL[2] !== 1'b1) begin bad++; $display("[TB] FAIL long_level_rel: got %b expected 1", KEY_LEVEL[2]); end
    goCycle(r + 7);
    total++;
    if (KEY_LEVEL[2] !== 1'b0) begin bad++; $display("[TB] FAIL long_level_drop: got %b expected 0", KEY_LEVEL[2]); end
    goCycle(r + 15);
    test_drained("long_hold");
  endtask

  task automatic test_release_bounce();
    int p, r;
    p = cyc;
    KEY[2] = 1'b0;
    expQ.push_back('{key: 2, cycle: p + LAT});
    expQ.push_back('{key: 2, cycle: p + LAT + LNG});
    goCycle(p + 30);
    r = cyc;
    KEY[2] = 1'b1;
    goCycle(r + 3);
    KEY[2] = 1'b0;
    @(negedge CLK);
    KEY[2] = 1'b1;
    goCycle(r + 8);
    total++;
    if (KEY_LONG[2] !== 1'b0) begin bad++; $display("[TB] FAIL relb_long: got %b expected 0", KEY_LONG[2]); end
    goCycle(r + 10);
    total++;
    if (KEY_LEVEL[2] !== 1'b1) begin bad++; $display("[TB] FAIL relb_level_hold: got %b expected 1", KEY_LEVEL[2]); end
    goCycle(r + 11);
    total++;
    if (KEY_LEVEL[2] !== 1'b0) begin bad++; $display("[TB] FAIL relb_level_drop: got %b expected 0", KEY_LEVEL[2]); end
    goCycle(r + 20);
    test_drained("release_bounce");
  endtask

  task automatic test_two_keys();
    int p;
    p = cyc;
    KEY[1] = 1'b0;
    KEY[2] = 1'b0;
    expQ.push_back('{key: 1, cycle: p + LAT});
    expQ.push_back('{key: 2, cycle: p + LAT});
    expQ.push_back('{key: 1, cycle: p + LAT + LNG});
    expQ.push_back('{key: 2, cycle: p + LAT + LNG});
    goCycle(p + LAT);
    while (cyc < p + 40) begin
      total++;
      if (ANY_KEY !== 1'b1) begin bad++; $display("[TB] FAIL two_any: got %b expected 1 at cycle %0d", ANY_KEY, cyc); end
      if (cyc == p + LAT + LNG) begin
        total++;
        if (KEY_LONG !== 5'b00110) begin bad++; $display("[TB] FAIL two_long: got %b expected 00110", KEY_LONG); end
      end
      @(negedge CLK);
    end
    KEY[1] = 1'b1;
    KEY[2] = 1'b1;
    goCycle(p + 47);
    total++;
    if (KEY_LEVEL !== '0) begin bad++; $display("[TB] FAIL two_level_drop: got %b expected 0", KEY_LEVEL); end
    goCycle(p + 55);
    test_drained("two_keys");
  endtask

  task automatic test_reset_mid_repeat();
    int p, e;
    p = cyc;
    KEY[3] = 1'b0;
    expQ.push_back('{key: 3, cycle: p + LAT});
    expQ.push_back('{key: 3, cycle: p + LAT + LNG});
    expQ.push_back('{key: 3, cycle: p + LAT + LNG + REP});
    goCycle(p + 38);
    RESETN = 1'b1;
    @(negedge CLK);
    e = cyc;
    RESETN = 1'b0;
    expQ.push_back('{key: 3, cycle: e + LAT});
    total += 3;
    if (KEY_LEVEL !== '0) begin bad++; $display("[TB] FAIL rst_rep_level: got %b expected 0", KEY_LEVEL); end
    if (KEY_LONG !== '0) begin bad++; $display("[TB] FAIL rst_rep_long: got %b expected 0", KEY_LONG); end
    if (ANY_KEY !== 1'b0) begin bad++; $display("[TB] FAIL rst_rep_any: got %b expected 0", ANY_KEY); end
    goCycle(e + LAT - 1);
    total++;
    if (KEY_LEVEL[3] !== 1'b0) begin bad++; $display("[TB] FAIL rst_rep_redeb: got %b expected 0", KEY_LEVEL[3]); end
    goCycle(e + LAT);
    total++;
    if (KEY_LEVEL[3] !== 1'b1) begin bad++; $display("[TB] FAIL rst_rep_level_back: got %b expected 1", KEY_LEVEL[3]); end
    goCycle(e + 11);
    KEY[3] = 1'b1;
    goCycle(e + 25);
    test_drained("reset_mid_repeat");
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_bounce();
    test_two_keys();
    test_reset_mid_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
